// File: rtl/alu_pkg.sv
// alu_pkg: widths, op encodings and op legality helper shared by the ALU arbiter slice
// Contents: ALU_W (datapath width), OP_W (op_sel width), op_e (op encodings), is_legal_op()
package alu_pkg;
   localparam int ALU_W = 4;
   localparam int OP_W  = 3;
   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101
   } op_e;
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return op <= OP_NOT;
   endfunction
endpackage

// File: rtl/alu_4bit.sv
// alu_4bit: combinational 4-bit ALU (ADD, SUB, AND, OR, XOR, NOT)
// Ports: a, b   operands
//        op     op_sel (alu_pkg encodings)
//        result ALU result
//        carry  ADD carry-out, SUB borrow (a < b), 0 for logic ops
module alu_4bit
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [ALU_W-1:0] result,
   output logic             carry
);
   logic [ALU_W:0] sum, diff;
   assign sum  = {1'b0, a} + {1'b0, b};
   // the extra bit of the wrapped difference is set exactly when a < b
   assign diff = {1'b0, a} - {1'b0, b};
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = sum;
         OP_SUB:  {carry, result} = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/alu_rr_grant.sv
// alu_rr_grant: combinational round-robin picker, first requester after last wins
// Ports: req        per-requester request
//        last       index granted most recently
//        grant      one-hot grant (zero when no request)
//        grant_idx  index of the granted requester
//        any        some requester is granted
module alu_rr_grant #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);
   logic [ID_W-1:0] idx;
   // walk offsets from farthest to nearest so the nearest requester after last overwrites the rest
   always_comb begin
      idx       = '0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(last) + k) % NUM_REQ);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any        = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 4-bit ALU among NUM_REQ requesters
// Ports: clk, rst                  clock, async active-high reset
//        req_valid/req_ready       per-requester handshake (ready is one-hot or zero)
//        req_a, req_b, req_op      packed per-requester operands and op_sel
//        rsp_valid/rsp_ready       response register handshake
//        rsp_id                    requester owning the response
//        rsp_result, rsp_carry     ALU result and carry/borrow
//        rsp_zero, rsp_err         result-is-zero, illegal op seen
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [ALU_W*NUM_REQ-1:0] req_a,
   input  logic [ALU_W*NUM_REQ-1:0] req_b,
   input  logic [OP_W*NUM_REQ-1:0]  req_op,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [ALU_W-1:0]         rsp_result,
   output logic                     rsp_carry,
   output logic                     rsp_zero,
   output logic                     rsp_err
);
   logic [ID_W-1:0]    last, grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any, can_accept, fire, legal, alu_carry;
   logic [ALU_W-1:0]   alu_a, alu_b, alu_result;
   logic [OP_W-1:0]    alu_op;
   alu_rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_grant (
      .req(req_valid), .last(last), .grant(grant), .grant_idx(grant_idx), .any(any)
   );
   assign can_accept = ~rsp_valid | rsp_ready;
   // rst gate keeps ready low while reset holds the response register empty
   assign req_ready  = (rst | ~can_accept) ? '0 : grant;
   assign fire       = |(req_valid & req_ready);
   // operand mux falls back to requester 0 when nobody is granted
   always_comb begin
      alu_a  = req_a[ALU_W-1:0];
      alu_b  = req_b[ALU_W-1:0];
      alu_op = req_op[OP_W-1:0];
      for (int i = 1; i < NUM_REQ; i++) begin
         if (any && grant_idx == ID_W'(i)) begin
            alu_a  = req_a[i*ALU_W +: ALU_W];
            alu_b  = req_b[i*ALU_W +: ALU_W];
            alu_op = req_op[i*OP_W +: OP_W];
         end
      end
   end
   alu_4bit u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result), .carry(alu_carry));
   assign legal = is_legal_op(alu_op);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         last       <= ID_W'(NUM_REQ - 1);
      end else if (fire) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= grant_idx;
         rsp_result <= legal ? alu_result : '0;
         rsp_carry  <= legal & alu_carry;
         rsp_zero   <= legal ? (alu_result == '0) : 1'b1;
         rsp_err    <= ~legal;
         last       <= grant_idx;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end
endmodule
